// File: rtl/mac_acc_pkg.sv
// Shared types and default parameters for the MAC accumulator.
package mac_acc_pkg;

  localparam int unsigned DefProdW = 16;
  localparam int unsigned DefAccW  = 20;
  localparam int unsigned DefLen   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } mac_state_e;

endpackage

// File: rtl/mac_acc_add.sv
// Accumulator adder with carry-out; MAC_ACC_SAT_EN clamps the sum to all-ones on carry.
module mac_acc_add
  import mac_acc_pkg::*;
#(
  parameter int unsigned PROD_W = DefProdW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  // One extra bit captures the carry out of ACC_W.
  assign full  = {1'b0, acc} + (ACC_W + 1)'(product);
  assign carry = full[ACC_W];

`ifdef MAC_ACC_SAT_EN
  assign sum = carry ? '1 : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Frame accumulator: sums LEN products, presents the sum with a sticky overflow flag.
// Build option MAC_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module mac_accumulator
  import mac_acc_pkg::*;
#(
  parameter int unsigned PROD_W = DefProdW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned LEN    = DefLen
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_ovf
);

  localparam int unsigned    CntW    = $clog2(LEN + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(LEN - 1);

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum;
  logic             carry;

  mac_acc_add #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc    (acc_q),
    .product(product),
    .sum    (sum),
    .carry  (carry)
  );

  assign in_ready  = (state_q != StHold);
  assign out_valid = (state_q == StHold);
  assign acc_out   = acc_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (in_valid) begin
            acc_d   = sum;
            cnt_d   = cnt_q + CntW'(1);
            ovf_d   = ovf_q | carry;
            state_d = (cnt_q == LastCnt) ? StHold : StAccum;
          end
        end
        StHold: begin
          if (out_ready) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: vector table, clr/reset sequences, random frames.
module tb_mac_accumulator;

  localparam int unsigned ProdW  = 16;
  localparam int unsigned AccW   = 17;
  localparam int unsigned Len    = 4;
  localparam longint      AccMax = (longint'(1) << AccW) - 1;

`ifdef MAC_ACC_SAT_EN
  localparam logic [16:0] OvfAccA = 17'd131071;
  localparam logic [16:0] OvfAccB = 17'd131071;
`else
  localparam logic [16:0] OvfAccA = 17'd131068;
  localparam logic [16:0] OvfAccB = 17'd0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [ProdW-1:0]  product;
  logic [AccW-1:0]   acc_out;
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  mac_accumulator #(
    .PROD_W(ProdW),
    .ACC_W (AccW),
    .LEN   (Len)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .product  (product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .out_ovf  (out_ovf)
  );

  typedef struct packed {
    logic [3:0][15:0] p;
    logic [3:0]       gap;
    logic [3:0]       hold;
    logic [16:0]      exp_acc;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Frame result from plain arithmetic on the true sum.
  function automatic void ref_frame(input logic [3:0][15:0] p, output logic [16:0] acc,
                                    output logic ovf);
    longint s = 0;
    for (int i = 0; i < 4; i++) s += longint'(p[i]);
    ovf = (s > AccMax);
`ifdef MAC_ACC_SAT_EN
    acc = ovf ? AccW'(AccMax) : AccW'(s);
`else
    acc = AccW'(s % (AccMax + 1));
`endif
  endfunction

  task automatic feed(input logic [15:0] v);
    in_valid = 1'b1;
    product  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [3:0][15:0] p, input int gap,
                           input int hold, input logic [16:0] ea, input logic eo);
    out_ready = (hold == 0);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        product  = 16'($urandom);
        step();
      end
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      product  = p[i];
      step();
    end
    // Offer a product throughout HOLD; it must never be accepted.
    in_valid = 1'b1;
    product  = 16'hffff;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_acc"}, 32'(acc_out), 32'(ea));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
    chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_acc"}, 32'(acc_out), 32'(ea));
      chk({tag, "_hold_ovf"}, 32'(out_ovf), 32'(eo));
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_acc"}, 32'(acc_out), 32'd0);
    chk({tag, "_post_ovf"}, 32'(out_ovf), 32'd0);
    chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0][15:0] rp;
    logic [16:0]      racc;
    logic             rovf;

    vecs[0] = '{p: {16'd400, 16'd300, 16'd200, 16'd100}, gap: 4'd0, hold: 4'd0,
                exp_acc: 17'd1000, exp_ovf: 1'b0};
    vecs[1] = '{p: {16'd400, 16'd300, 16'd200, 16'd100}, gap: 4'd2, hold: 4'd5,
                exp_acc: 17'd1000, exp_ovf: 1'b0};
    vecs[2] = '{p: {16'd65535, 16'd65535, 16'd65535, 16'd65535}, gap: 4'd0, hold: 4'd1,
                exp_acc: OvfAccA, exp_ovf: 1'b1};
    vecs[3] = '{p: {16'd0, 16'd1, 16'd65535, 16'd65535}, gap: 4'd1, hold: 4'd0,
                exp_acc: 17'd131071, exp_ovf: 1'b0};
    vecs[4] = '{p: {16'd0, 16'd2, 16'd65535, 16'd65535}, gap: 4'd0, hold: 4'd2,
                exp_acc: OvfAccB, exp_ovf: 1'b1};
    vecs[5] = '{p: {16'd0, 16'd0, 16'd0, 16'd0}, gap: 4'd0, hold: 4'd0,
                exp_acc: 17'd0, exp_ovf: 1'b0};

    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    product   = '0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].p, int'(vecs[v].gap), int'(vecs[v].hold),
                vecs[v].exp_acc, vecs[v].exp_ovf);
    end

    // clr mid-frame; product in the clr cycle is ignored.
    feed(16'd5);
    feed(16'd7);
    chk("clr_partial", 32'(acc_out), 32'd12);
    clr      = 1'b1;
    in_valid = 1'b1;
    product  = 16'd99;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_acc", 32'(acc_out), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    run_frame("after_clr", {16'd4, 16'd3, 16'd2, 16'd1}, 0, 1, 17'd10, 1'b0);

    // clr in HOLD discards a pending overflowed result.
    for (int i = 0; i < 4; i++) feed(16'd65535);
    chk("clr_hold_valid_pre", 32'(out_valid), 32'd1);
    chk("clr_hold_ovf_pre", 32'(out_ovf), 32'd1);
    clr       = 1'b1;
    out_ready = 1'b1;
    step();
    clr       = 1'b0;
    out_ready = 1'b0;
    chk("clr_hold_valid", 32'(out_valid), 32'd0);
    chk("clr_hold_acc", 32'(acc_out), 32'd0);
    chk("clr_hold_ovf", 32'(out_ovf), 32'd0);

    // Reset mid-frame and in HOLD, acting without a clock edge.
    feed(16'd50);
    feed(16'd60);
    chk("rst_mid_partial", 32'(acc_out), 32'd110);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_acc", 32'(acc_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("rst_mid_next", {16'd1, 16'd1, 16'd1, 16'd1}, 0, 0, 17'd4, 1'b0);
    for (int i = 0; i < 4; i++) feed(16'd1);
    chk("rst_hold_valid_pre", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_acc", 32'(acc_out), 32'd0);
    chk("rst_hold_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("rst_hold_next", {16'd1, 16'd1, 16'd1, 16'd1}, 1, 1, 17'd4, 1'b0);

    // Random frames against the arithmetic model, with occasional aborts.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        int k = int'($urandom_range(1, 3));
        for (int i = 0; i < k; i++) feed(16'($urandom));
        clr      = 1'b1;
        in_valid = 1'b1;
        product  = 16'($urandom);
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("rnd_clr_acc", 32'(acc_out), 32'd0);
        chk("rnd_clr_ovf", 32'(out_ovf), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
        rp[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(50000, 65535))
                                            : 16'($urandom);
      end
      ref_frame(rp, racc, rovf);
      run_frame($sformatf("rnd%0d", f), rp, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), racc, rovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter PROD_W, default 16, width of each incoming product.
REQ-002 Parameter ACC_W, default 20, accumulator and result width; SHALL be at least PROD_W.
REQ-003 Parameter LEN, default 8, number of products per frame; legal range 2..256.
REQ-004 Port clk  input  1  single clock; all logic SHALL act on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port clr  input  1  synchronous frame abort.
REQ-007 Port in_valid  input  1  product is valid.
REQ-008 Port in_ready  output  1  block accepts a product.
REQ-009 Port product  input  PROD_W  unsigned product from the multiplier stage.
REQ-010 Port out_valid  output  1  acc_out is valid.
REQ-011 Port out_ready  input  1  consumer accepts acc_out.
REQ-012 Port acc_out  output  ACC_W  unsigned frame sum.
REQ-013 Port out_ovf  output  1  frame sum exceeded 2^ACC_W-1.

Function
REQ-014 A product SHALL be accepted in a cycle where in_valid and in_ready are both 1.
REQ-015 The FSM SHALL have the states IDLE (count=0), ACCUM (0<count<LEN) and HOLD (result presented).
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-017 Each accepted product SHALL be zero-extended to ACC_W and added to the accumulator.
REQ-018 Accepting a product SHALL increment count.
REQ-019 Accepting the LEN-th product SHALL move the FSM to HOLD.
REQ-020 out_valid SHALL rise the cycle after the LEN-th acceptance, so latency from the last product to out_valid is 1 cycle.
REQ-021 In HOLD, acc_out and out_ovf SHALL stay stable until out_valid and out_ready are both 1.
REQ-022 On that output transfer, the next cycle SHALL be IDLE with accumulator=0, count=0, out_ovf=0 and out_valid=0.
REQ-023 out_ovf SHALL go to 1 on any addition that produces a carry out of ACC_W, and SHALL then hold 1 until the frame ends.
REQ-024 clr SHALL have priority over every other input.
REQ-025 clr SHALL return the FSM to IDLE with accumulator, count and out_ovf zeroed and out_valid=0, discarding any pending result even in HOLD.
REQ-026 A product presented in the same cycle as clr SHALL be ignored.
REQ-027 In_valid asserted with a product in HOLD SHALL NOT be accepted, and the accumulator SHALL be unchanged.
REQ-028 Gaps in in_valid SHALL NOT affect the sum.
REQ-029 Back-to-back frames SHALL sustain one product per cycle, plus at least one HOLD cycle per frame.

Reset
REQ-030 While rst_n=0, state SHALL be IDLE and accumulator, count, acc_out, out_valid and out_ovf SHALL be 0, independent of clk.
REQ-031 Deassertion of rst_n in the middle of a frame SHALL start a fresh frame, with no partial sum retained.

Configuration
REQ-032 The feature macro SHALL be MAC_ACC_SAT_EN.
REQ-033 With MAC_ACC_SAT_EN defined, an overflowing addition SHALL clamp the accumulator to 2^ACC_W-1, and it SHALL stay clamped for the rest of the frame.
REQ-034 Without MAC_ACC_SAT_EN, the accumulator SHALL wrap modulo 2^ACC_W.
REQ-035 out_ovf SHALL behave identically in both builds.

Structure
REQ-036 Package mac_acc_pkg SHALL hold the FSM state typedef and the default values of PROD_W, ACC_W and LEN.
REQ-037 The adder, including its carry output and the MAC_ACC_SAT_EN clamp, SHALL be the sub-module mac_acc_add.
REQ-038 The count register width SHALL be derived as clog2(LEN+1).

Verification
REQ-039 LEN=4, products 100,200,300,400 back-to-back, out_ready=1 -> out_valid 1 cycle after the 4th product; acc_out=1000; out_ovf=0.
REQ-040 LEN=4, same products with in_valid gaps, out_ready held 0 for 5 cycles -> acc_out=1000 stable, in_ready=0 throughout HOLD, the next frame starts from 0.
REQ-041 ACC_W=17, LEN=4, four products of 65535 -> without the macro acc_out=131068 and out_ovf=1; with MAC_ACC_SAT_EN acc_out=131071 and out_ovf=1.
REQ-042 LEN=4, clr after 2 products (5,7), then products 1,2,3,4 -> acc_out=10, and the first frame is never output.
REQ-043 rst_n pulsed low mid-frame and again in HOLD -> out_valid drops immediately, and the next complete frame of 1,1,1,1 gives acc_out=4.
